zero_detect_pipe: RTL and testbench
===================================

# zero_detect_pipe

Parametrised, pipelined reduction unit that generalises the 32-bit OR-tree nonzero detector. Width and pipeline depth are configurable, and each word can select one of four reduction modes. Results are delivered over a valid/ready handshake with backpressure, and the block keeps a sticky hit flag and a saturating hit counter. It sits between the ALU/compare datapath and the game-logic controller, which polls it for "any card bit set", "hand equals target", and parity checks.

## Interface
Parameters:
- WIDTH, 32, data width in bits; any value ≥ 2.
- LEVELS_PER_STAGE, 2, number of 2-input tree levels between pipeline registers; ≥ 1.
- COUNT_W, 8, width of the hit counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- in_valid  in  1  input word is present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  operand.
- in_cmp  in  WIDTH  compare operand; used only in mode 3.
- in_mode  in  2  0 ANY, 1 ALL, 2 PARITY, 3 EQ.
- out_valid  out  1  a result is present.
- out_ready  in  1  downstream consumes the result.
- out_result  out  1  reduction result.
- out_mode  out  2  mode that produced out_result.
- clear_sticky  in  1  clears sticky_hit and hit_count.
- sticky_hit  out  1  set when any consumed result was 1.
- hit_count  out  COUNT_W  number of consumed results equal to 1; saturates.

## Operation
- Per-mode results:
  - ANY: OR of all bits, so 1 if in_data ≠ 0 (same polarity as the existing detector).
  - ALL: AND of all bits.
  - PARITY: XOR of all bits.
  - EQ: AND of ~(in_data ^ in_cmp), so 1 if in_data == in_cmp.
- Tree depth D = ceil(log2 WIDTH). The tree is built as pairwise 2-input levels.
- Padding for non-power-of-2 WIDTH: leaves up to 2^D are padded with the mode's identity value (0 for ANY/PARITY, 1 for ALL/EQ).
- Register stages: S = max(1, ceil(D / LEVELS_PER_STAGE)). The last register drives out_result.
- Each stage register holds partial sums, a valid bit and the mode. The mode travels with its data.
- Flow control is a global enable: en = !out_valid || out_ready, and in_ready = en.
  - When en = 1, every stage shifts forward by one.
  - A word is accepted when in_valid && in_ready.
  - Bubbles are not squeezed out.
- A result is consumed when out_valid && out_ready. On consumption, if out_result = 1:
  - sticky_hit sets to 1.
  - hit_count increments; it saturates at 2^COUNT_W − 1 and never wraps.
- clear_sticky zeroes sticky_hit and hit_count.
  - If a hit is consumed in the same cycle as clear_sticky, the new event wins: sticky_hit = 1 and hit_count = 1.
- clear_sticky has no effect on the pipeline contents.

## Timing
- Reset values: out_valid = 0, out_result = 0, out_mode = 0, sticky_hit = 0, hit_count = 0, and every stage valid bit = 0.
- in_ready = 1 in the first cycle after reset, since out_valid = 0.
- Latency: a word accepted at edge t appears with out_valid = 1 after edge t + S − 1, given no stall. For WIDTH = 32 and LEVELS_PER_STAGE = 2, S = 3.
- Throughput: one word per cycle when out_ready is held at 1.
- Stall: with out_valid = 1 and out_ready = 0, all outputs hold stable and in_ready = 0. Upstream must hold its word.
- Reset asserted mid-stream discards every in-flight word. Outputs return to their reset values on that same edge.
- in_data, in_cmp and in_mode are sampled only on accept; other cycles ignore them.
- There is no combinational path from in_valid or in_data to any output. in_ready depends combinationally only on out_valid and out_ready.

## Test plan
Default parameters (WIDTH = 32, LEVELS_PER_STAGE = 2, S = 3) unless a scenario states otherwise.

- Reset, then ANY on 0x00000000 followed by ANY on 0x80000000 back to back, out_ready = 1 → results 0 then 1 on consecutive cycles. The first result arrives 2 cycles after its accept; sticky_hit = 1 and hit_count = 1 after the second result is consumed.
- ALL on 0xFFFFFFFF, ALL on 0xFFFFFFFE, PARITY on 0x00000007, EQ with data = cmp = 0x1234ABCD → results 1, 0, 1, 1, each with the matching out_mode.
- Accept 4 words, then hold out_ready = 0 for 5 cycles → out_result and out_mode stay stable and in_ready = 0. After release, all 4 results arrive in order with none lost or duplicated.
- COUNT_W = 2 with 5 consumed hits → hit_count reads 1, 2, 3, 3, 3. Then clear_sticky asserted in the same cycle as a hit is consumed → sticky_hit = 1 and hit_count = 1.
- WIDTH = 5, LEVELS_PER_STAGE = 1 (S = 3): ALL on 5'b11111 → 1; ANY on 5'b00000 → 0; PARITY on 5'b10000 → 1. Confirms padding does not corrupt results.
- Assert reset for 1 cycle while 3 words are in flight → out_valid = 0 on the next cycle, no stale result is ever emitted, and sticky_hit and hit_count are 0.

Source files
------------

// File: rtl/zero_detect_pipe_if.sv
// zero_detect_pipe_if: operand/result handshake and hit statistics
// bundle between the compare datapath and the game-logic controller.
interface zero_detect_pipe_if #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [WIDTH-1:0]   in_cmp;
   logic [1:0]         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic               out_result;
   logic [1:0]         out_mode;
   logic               clear_sticky;
   logic               sticky_hit;
   logic [COUNT_W-1:0] hit_count;

   modport master (
      output in_valid, in_data, in_cmp, in_mode,
      output out_ready, clear_sticky,
      input  in_ready, out_valid, out_result, out_mode,
      input  sticky_hit, hit_count
   );

   modport slave (
      input  in_valid, in_data, in_cmp, in_mode,
      input  out_ready, clear_sticky,
      output in_ready, out_valid, out_result, out_mode,
      output sticky_hit, hit_count
   );
endinterface

// File: rtl/zero_detect_pipe.sv
// zero_detect_pipe: pipelined ANY/ALL/PARITY/EQ reduction tree with
// global-enable valid/ready flow control and sticky hit statistics.
module zero_detect_pipe #(
   parameter int WIDTH            = 32,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int COUNT_W          = 8
) (
   input logic               clock,
   input logic               reset,
   zero_detect_pipe_if.slave bus
);
   localparam int D  = $clog2(WIDTH);
   localparam int NP = 1 << D;
   localparam int L  = LEVELS_PER_STAGE;
   localparam int S  = (D < 1) ? 1 : (D + L - 1) / L;

   localparam logic [1:0] MODE_ANY = 2'd0;
   localparam logic [1:0] MODE_ALL = 2'd1;
   localparam logic [1:0] MODE_PAR = 2'd2;
   localparam logic [1:0] MODE_EQ  = 2'd3;

   // Width of the partial-sum vector held by stage register g.
   function automatic int stg_ow(int g);
      int lv;
      lv = (g + 1) * L;
      if (lv > D) lv = D;
      return 1 << (D - lv);
   endfunction

   function automatic int stg_off(int g);
      int o;
      o = 0;
      for (int j = 0; j < g; j++) o += stg_ow(j);
      return o;
   endfunction

   localparam int TOT = stg_off(S);

   function automatic logic red2(
      logic [1:0] m,
      logic       a,
      logic       b
   );
      logic r;
      unique case (1'b1)
         (m == MODE_ANY): r = a | b;
         (m == MODE_PAR): r = a ^ b;
         default:         r = a & b;
      endcase
      return r;
   endfunction

   logic [NP-1:0]    leaf;
   logic [WIDTH-1:0] bits;
   logic             pad;
   logic             en;
   logic             acc;
   logic             hit;

   wire  [TOT-1:0]   data_d;
   logic [TOT-1:0]   data_q;
   wire  [S-1:0]     valid_d;
   logic [S-1:0]     valid_q;
   wire  [2*S-1:0]   mode_d;
   logic [2*S-1:0]   mode_q;

   logic               sticky_d;
   logic               sticky_q;
   logic [COUNT_W-1:0] count_d;
   logic [COUNT_W-1:0] count_q;

   // Leaves beyond WIDTH carry the identity of the selected reduction.
   always_comb begin
      pad = (bus.in_mode == MODE_ALL) || (bus.in_mode == MODE_EQ);
      if (bus.in_mode == MODE_EQ) bits = ~(bus.in_data ^ bus.in_cmp);
      else                        bits = bus.in_data;
      leaf = {NP{pad}};
      leaf[WIDTH-1:0] = bits;
   end

   always_comb begin
      en  = !valid_q[S-1] || bus.out_ready;
      acc = bus.in_valid && en;
      hit = valid_q[S-1] && bus.out_ready && data_q[TOT-1];
   end

   for (genvar g = 0; g < S; g++) begin : g_stg
      localparam int IW = (g == 0) ? NP : stg_ow(g - 1);
      localparam int OW = stg_ow(g);
      localparam int NL = $clog2(IW / OW);

      logic [IW-1:0] src;
      logic [1:0]    src_m;
      logic [IW-1:0] t;

      if (g == 0) begin : g_head
         assign src        = leaf;
         assign src_m      = bus.in_mode;
         assign valid_d[0] = acc;
      end else begin : g_body
         assign src        = data_q[stg_off(g - 1) +: IW];
         assign src_m      = mode_q[2*(g-1) +: 2];
         assign valid_d[g] = valid_q[g-1];
      end

      // In-place pairwise folding: slot i only reads slots >= i.
      always_comb begin
         t = src;
         for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < (IW >> (l + 1)); i++) begin
               t[i] = red2(src_m, t[2*i], t[2*i+1]);
            end
         end
      end

      assign data_d[stg_off(g) +: OW] = t[OW-1:0];
      assign mode_d[2*g +: 2]         = src_m;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= '0;
         mode_q  <= '0;
      end else if (en) begin
         data_q  <= data_d;
         valid_q <= valid_d;
         mode_q  <= mode_d;
      end
   end

   // A hit consumed together with clear_sticky restarts the count at 1.
   always_comb begin
      sticky_d = sticky_q;
      count_d  = count_q;
      if (hit) begin
         sticky_d = 1'b1;
         if (bus.clear_sticky)   count_d = COUNT_W'(1);
         else if (count_q != '1) count_d = count_q + COUNT_W'(1);
      end else if (bus.clear_sticky) begin
         sticky_d = 1'b0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign bus.in_ready   = en;
   assign bus.out_valid  = valid_q[S-1];
   assign bus.out_result = data_q[TOT-1];
   assign bus.out_mode   = mode_q[2*S-1 -: 2];
   assign bus.sticky_hit = sticky_q;
   assign bus.hit_count  = count_q;
endmodule

// File: tb/tb_zero_detect_pipe.sv
// tb_zero_detect_pipe: three configurations driven in lockstep and
// checked against a spec-level model plus literal expectations.
module tb_zero_detect_pipe;
   logic clock;
   logic reset;

   zero_detect_pipe_if #(.WIDTH(32), .COUNT_W(8)) b1 ();
   zero_detect_pipe_if #(.WIDTH(32), .COUNT_W(2)) b2 ();
   zero_detect_pipe_if #(.WIDTH(5),  .COUNT_W(8)) b3 ();

   zero_detect_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .COUNT_W(8)) dut_main (
      .clock(clock), .reset(reset), .bus(b1)
   );
   zero_detect_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .COUNT_W(2)) dut_cnt (
      .clock(clock), .reset(reset), .bus(b2)
   );
   zero_detect_pipe #(.WIDTH(5), .LEVELS_PER_STAGE(1), .COUNT_W(8)) dut_nar (
      .clock(clock), .reset(reset), .bus(b3)
   );

   assign b2.in_valid     = b1.in_valid;
   assign b2.in_data      = b1.in_data;
   assign b2.in_cmp       = b1.in_cmp;
   assign b2.in_mode      = b1.in_mode;
   assign b2.out_ready    = b1.out_ready;
   assign b2.clear_sticky = b1.clear_sticky;
   assign b3.in_valid     = b1.in_valid;
   assign b3.in_data      = b1.in_data[4:0];
   assign b3.in_cmp       = b1.in_cmp[4:0];
   assign b3.in_mode      = b1.in_mode;
   assign b3.out_ready    = b1.out_ready;
   assign b3.clear_sticky = b1.clear_sticky;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: reduce the masked operand with plain arithmetic.
   function automatic bit ref_res(logic [1:0] m, logic [31:0] d,
                                  logic [31:0] c, int w);
      logic [31:0] mask, dd, cc;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      dd = d & mask;
      cc = c & mask;
      case (m)
         2'd0:    return dd != 0;
         2'd1:    return dd == mask;
         2'd2:    return ^dd;
         default: return dd == cc;
      endcase
   endfunction

   // Model: three in-flight slots (latency 3), index 2 is the output.
   bit       mv [3];
   bit       mr [3][3];
   bit [1:0] mm [3];
   bit       ms [3];
   int       mc [3];
   int       cmax [3] = '{255, 3, 255};
   int       mw [3]   = '{32, 32, 5};
   bit       m_en;

   always @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mm[k] = 0; ms[k] = 0; mc[k] = 0;
            for (int j = 0; j < 3; j++) mr[k][j] = 0;
         end
      end else begin
         m_en = !mv[2] || b1.out_ready;
         for (int k = 0; k < 3; k++) begin
            if (mv[2] && b1.out_ready && mr[2][k]) begin
               ms[k] = 1;
               if (b1.clear_sticky)   mc[k] = 1;
               else if (mc[k] < cmax[k]) mc[k] = mc[k] + 1;
            end else if (b1.clear_sticky) begin
               ms[k] = 0;
               mc[k] = 0;
            end
         end
         if (m_en) begin
            for (int s = 2; s > 0; s--) begin
               mv[s] = mv[s-1];
               mm[s] = mm[s-1];
               for (int k = 0; k < 3; k++) mr[s][k] = mr[s-1][k];
            end
            mv[0] = b1.in_valid;
            mm[0] = b1.in_mode;
            for (int k = 0; k < 3; k++)
               mr[0][k] = ref_res(b1.in_mode, b1.in_data, b1.in_cmp, mw[k]);
         end
      end
   end

   task automatic chk_dut(input string tag, input int k, input logic ov,
                          input logic orr, input logic [1:0] om,
                          input logic sh, input logic [7:0] hc);
      chk({tag, " out_valid"}, ov, mv[2]);
      if (mv[2]) begin
         chk({tag, " out_result"}, orr, mr[2][k]);
         chk({tag, " out_mode"}, om, mm[2]);
      end
      chk({tag, " sticky_hit"}, sh, ms[k]);
      chk({tag, " hit_count"}, hc, mc[k]);
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         chk("in_ready", b1.in_ready, !mv[2] || b1.out_ready);
         chk_dut("main", 0, b1.out_valid, b1.out_result, b1.out_mode,
                 b1.sticky_hit, b1.hit_count);
         chk_dut("cnt2", 1, b2.out_valid, b2.out_result, b2.out_mode,
                 b2.sticky_hit, 8'(b2.hit_count));
         chk_dut("w5", 2, b3.out_valid, b3.out_result, b3.out_mode,
                 b3.sticky_hit, b3.hit_count);
      end
   end

   logic [1:0]  sq_m [8];
   logic [31:0] sq_d [8];
   logic [31:0] sq_c [8];
   bit          ex_m [8];
   bit          ex_n [8];
   int          hc_seen [8];

   task automatic set_w(input int i, input logic [1:0] m, input logic [31:0] d,
                        input logic [31:0] c, input bit em, input bit en5);
      sq_m[i] = m; sq_d[i] = d; sq_c[i] = c; ex_m[i] = em; ex_n[i] = en5;
   endtask

   // Stream n words with an optional out_ready stall window; results
   // are compared against ex_m/ex_n in consumption order.
   task automatic run_seq(input int n, input int stall_at, input int stall_len,
                          input int clr_idx, input string tag);
      int sent, got, c;
      bit cons, acc;
      logic hr;
      logic [1:0] hm;
      sent = 0; got = 0; c = 0; hr = 0; hm = 0;
      while (got < n && c < 40) begin
         b1.out_ready    = !(c >= stall_at && c < stall_at + stall_len);
         b1.in_valid     = (sent < n);
         b1.clear_sticky = 1'b0;
         if (sent < n) begin
            b1.in_mode = sq_m[sent];
            b1.in_data = sq_d[sent];
            b1.in_cmp  = sq_c[sent];
         end
         #1;
         if (!b1.out_ready) begin
            chk({tag, " stall in_ready"}, b1.in_ready, 0);
            if (c == stall_at) begin
               hr = b1.out_result;
               hm = b1.out_mode;
            end else begin
               chk({tag, " stall result"}, b1.out_result, hr);
               chk({tag, " stall mode"}, b1.out_mode, hm);
            end
         end
         cons = b1.out_valid && b1.out_ready;
         if (cons) begin
            chk({tag, " result"}, b1.out_result, ex_m[got]);
            chk({tag, " mode"}, b1.out_mode, sq_m[got]);
            chk({tag, " w5 result"}, b3.out_result, ex_n[got]);
            if (got == clr_idx) b1.clear_sticky = 1'b1;
         end
         acc = b1.in_valid && b1.in_ready;
         @(posedge clock);
         if (acc) sent++;
         #1;
         if (cons) begin
            hc_seen[got] = int'(b2.hit_count);
            got++;
         end
         b1.clear_sticky = 1'b0;
         c++;
      end
      b1.in_valid = 1'b0;
      chk({tag, " results delivered"}, got, n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int r;
      reset = 1'b1;
      b1.in_valid = 0; b1.in_data = 0; b1.in_cmp = 0; b1.in_mode = 0;
      b1.out_ready = 1; b1.clear_sticky = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk_on = 1;
      chk("rst out_valid", b1.out_valid, 0);
      chk("rst out_result", b1.out_result, 0);
      chk("rst out_mode", b1.out_mode, 0);
      chk("rst sticky", b1.sticky_hit, 0);
      chk("rst hit_count", b1.hit_count, 0);
      chk("rst in_ready", b1.in_ready, 1);

      // ANY 0 then ANY 0x80000000 back to back
      b1.in_valid = 1; b1.in_mode = 0; b1.in_data = 0;
      @(posedge clock); #1;
      chk("any t out_valid", b1.out_valid, 0);
      b1.in_data = 32'h8000_0000;
      @(posedge clock); #1;
      chk("any t+1 out_valid", b1.out_valid, 0);
      b1.in_valid = 0;
      @(posedge clock); #1;
      chk("any t+2 out_valid", b1.out_valid, 1);
      chk("any t+2 result", b1.out_result, 0);
      @(posedge clock); #1;
      chk("any t+3 out_valid", b1.out_valid, 1);
      chk("any t+3 result", b1.out_result, 1);
      @(posedge clock); #1;
      chk("any sticky", b1.sticky_hit, 1);
      chk("any hit_count", b1.hit_count, 1);

      set_w(0, 2'd1, 32'hFFFF_FFFF, 0, 1, 1);
      set_w(1, 2'd1, 32'hFFFF_FFFE, 0, 0, 0);
      set_w(2, 2'd2, 32'h0000_0007, 0, 1, 1);
      set_w(3, 2'd3, 32'h1234_ABCD, 32'h1234_ABCD, 1, 1);
      run_seq(4, 99, 0, -1, "modes");

      set_w(0, 2'd0, 32'h1, 0, 1, 1);
      set_w(1, 2'd0, 32'h0, 0, 0, 0);
      set_w(2, 2'd2, 32'h3, 0, 0, 0);
      set_w(3, 2'd1, 32'hFFFF_FFFF, 0, 1, 1);
      run_seq(4, 4, 5, -1, "stall");

      b1.clear_sticky = 1;
      @(posedge clock); #1;
      b1.clear_sticky = 0;
      chk("clr cnt2 hit_count", b2.hit_count, 0);
      for (int i = 0; i < 5; i++) set_w(i, 2'd0, 32'h1, 0, 1, 1);
      run_seq(5, 99, 0, -1, "sat");
      chk("sat hc0", hc_seen[0], 1);
      chk("sat hc1", hc_seen[1], 2);
      chk("sat hc2", hc_seen[2], 3);
      chk("sat hc3", hc_seen[3], 3);
      chk("sat hc4", hc_seen[4], 3);
      run_seq(1, 99, 0, 0, "clrhit");
      chk("clrhit main sticky", b1.sticky_hit, 1);
      chk("clrhit main count", b1.hit_count, 1);
      chk("clrhit cnt2 count", b2.hit_count, 1);

      set_w(0, 2'd1, 32'h0000_001F, 0, 0, 1);
      set_w(1, 2'd0, 32'h0000_0000, 0, 0, 0);
      set_w(2, 2'd2, 32'h0000_0010, 0, 1, 1);
      run_seq(3, 99, 0, -1, "pad");

      // Fill three stages behind a stalled output, then reset.
      b1.out_ready = 0; b1.in_valid = 1; b1.in_mode = 0; b1.in_data = 1;
      repeat (3) @(posedge clock);
      #1;
      chk("fill out_valid", b1.out_valid, 1);
      chk("fill in_ready", b1.in_ready, 0);
      reset = 1; b1.in_valid = 0;
      @(posedge clock); #1;
      reset = 0; b1.out_ready = 1;
      chk("midrst out_valid", b1.out_valid, 0);
      chk("midrst sticky", b1.sticky_hit, 0);
      chk("midrst hit_count", b1.hit_count, 0);
      chk("midrst cnt2 count", b2.hit_count, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         chk("midrst no stale", b1.out_valid, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 31);
         case ($urandom_range(0, 4))
            0:       d = 32'h0;
            1:       d = 32'hFFFF_FFFF;
            2:       d = 32'd1 << r;
            3:       d = ~(32'd1 << r);
            default: d = $urandom;
         endcase
         b1.in_valid     = ($urandom_range(0, 9) < 7);
         b1.out_ready    = ($urandom_range(0, 9) < 7);
         b1.clear_sticky = ($urandom_range(0, 99) < 3);
         reset           = ($urandom_range(0, 499) == 0);
         b1.in_mode      = 2'($urandom_range(0, 3));
         b1.in_data      = d;
         b1.in_cmp       = $urandom_range(0, 1) ? d : d ^ (32'd1 << $urandom_range(0, 31));
         @(posedge clock); #1;
      end
      reset = 0;
      b1.in_valid = 0;
      b1.clear_sticky = 0;
      @(posedge clock); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
